bitmap_coord_gen: RTL and testbench

//  Raster-scan coordinate generator that feeds the 3-cycle bitmap address stage.
//  On start it walks a w x h rectangle from (x0,y0) in row-major order, one coordinate per accepted cycle.

---
 rtl/bitmap_coord_if.sv | 34 +++
 rtl/bitmap_coord_gen.sv | 88 ++++++++
 tb/tb_bitmap_coord_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bitmap_coord_if.sv
// bitmap_coord_if: control/sink/address-stage signals of the raster coordinate generator
// BITMAP_COORD_GEN_MIRROR_EN adds the per-scan mirror request.
interface bitmap_coord_if #(parameter int CORDW = 16);
  logic             start;
  logic [CORDW-1:0] x0;
  logic [CORDW-1:0] y0;
  logic [CORDW-1:0] w;
  logic [CORDW-1:0] h;
`ifdef BITMAP_COORD_GEN_MIRROR_EN
  logic             mirror;
`endif
  logic             ready;
  logic [CORDW-1:0] x;
  logic [CORDW-1:0] y;
  logic             coord_vld;
  logic             pix_vld;
  logic             pix_last;
  logic             busy;
  logic             done;
  modport master (
    output start, x0, y0, w, h, ready,
`ifdef BITMAP_COORD_GEN_MIRROR_EN
    output mirror,
`endif
    input  x, y, coord_vld, pix_vld, pix_last, busy, done
  );
  modport slave (
    input  start, x0, y0, w, h, ready,
`ifdef BITMAP_COORD_GEN_MIRROR_EN
    input  mirror,
`endif
    output x, y, coord_vld, pix_vld, pix_last, busy, done
  );
endinterface

// File: rtl/bitmap_coord_gen.sv
// bitmap_coord_gen: row-major w x h raster walk with LAT-delayed valid/last for the address stage
// BITMAP_COORD_GEN_MIRROR_EN enables descending-x rows selected by the mirror input.
module bitmap_coord_gen #(
  parameter int CORDW = 16,
  parameter int LAT   = 3
) (
  input logic           clk,
  input logic           rst_n,
  bitmap_coord_if.slave bus
);
  localparam logic [CORDW-1:0] ONE = CORDW'(1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  state_t           state, state_n;
  logic [CORDW-1:0] bx, by, bw, bh, cx, cy, cx_n, cy_n, xoff_0, xoff_n;
  logic [LAT-1:0]   vld_dl, last_dl;
  logic             accept, empty, row_end, is_last, adv;
`ifdef BITMAP_COORD_GEN_MIRROR_EN
  logic             mir;
  assign xoff_0 = bus.mirror ? bus.w - ONE : '0;
  assign xoff_n = mir ? bw - ONE - cx_n : cx_n;
`else
  assign xoff_0 = '0;
  assign xoff_n = cx_n;
`endif
  assign bus.busy      = state == RUN || state == DRAIN;
  assign bus.done      = state == FIN;
  assign bus.coord_vld = adv;
  assign bus.pix_vld   = vld_dl[LAT-1];
  assign bus.pix_last  = last_dl[LAT-1];
  assign accept  = bus.start && !bus.busy;
  assign empty   = bus.w == '0 || bus.h == '0;
  assign adv     = state == RUN && bus.ready;
  assign row_end = cx == bw - ONE;
  assign is_last = row_end && cy == bh - ONE;
  assign cx_n    = row_end ? '0 : cx + ONE;
  assign cy_n    = row_end ? cy + ONE : cy;
  always_comb begin
    state_n = state;
    if (accept) state_n = empty ? FIN : RUN;
    else if (adv && is_last) state_n = DRAIN;
    else if (state == DRAIN && bus.pix_last) state_n = FIN;
    else if (state == FIN) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bx      <= '0;
      by      <= '0;
      bw      <= '0;
      bh      <= '0;
      cx      <= '0;
      cy      <= '0;
      bus.x   <= '0;
      bus.y   <= '0;
      vld_dl  <= '0;
      last_dl <= '0;
`ifdef BITMAP_COORD_GEN_MIRROR_EN
      mir     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      vld_dl[0]  <= adv;
      last_dl[0] <= adv && is_last;
      for (int i = 1; i < LAT; i++) begin
        vld_dl[i]  <= vld_dl[i-1];
        last_dl[i] <= last_dl[i-1];
      end
      if (accept) begin
        bx    <= bus.x0;
        by    <= bus.y0;
        bw    <= bus.w;
        bh    <= bus.h;
        cx    <= '0;
        cy    <= '0;
        bus.x <= bus.x0 + xoff_0;
        bus.y <= bus.y0;
`ifdef BITMAP_COORD_GEN_MIRROR_EN
        mir   <= bus.mirror;
`endif
      end else if (adv && !is_last) begin
        cx    <= cx_n;
        cy    <= cy_n;
        bus.x <= bx + xoff_n;
        bus.y <= by + cy_n;
      end
    end
  end
endmodule

// File: tb/tb_bitmap_coord_gen.sv
// tb_bitmap_coord_gen: directed scans with a coordinate/pixel scoreboard checked by a negedge monitor
module tb_bitmap_coord_gen;
  localparam int CORDW = 16;
  localparam int LAT   = 3;
`ifdef BITMAP_COORD_GEN_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bitmap_coord_if #(.CORDW(CORDW)) bus ();
  bitmap_coord_gen #(.CORDW(CORDW), .LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_done = -1, last_issue = -1;
  logic [32:0] cq[$];
  logic        pq[$];
  logic [32:0] e;
  logic [15:0] px, py;
  bit          p_ok = 1'b0, p_adv = 1'b0;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) p_ok = 1'b0;
    else begin
      if (p_ok && !p_adv) chk("hold_xy", {bus.x, bus.y}, {px, py});
      if (bus.coord_vld) begin
        chk("vld_needs_ready", bus.ready, 1);
        if (cq.size() == 0) chk("coord_extra", bus.coord_vld, 0);
        else begin
          e = cq.pop_front();
          chk("coord_xy", {bus.x, bus.y}, e[31:0]);
          pq.push_back(e[32]);
          if (e[32]) last_issue = cyc;
        end
      end
      if (bus.pix_vld) begin
        if (pq.size() == 0) chk("pix_extra", bus.pix_vld, 0);
        else begin
          chk("pix_last", bus.pix_last, pq.pop_front());
          if (bus.pix_last) begin
            chk("pix_last_lat", cyc, last_issue + LAT);
            exp_done = cyc + 1;
          end
        end
      end else if (bus.pix_last) chk("pix_last_alone", bus.pix_last, 0);
      if (bus.done) begin
        done_cnt++;
        chk("done_time", cyc, exp_done);
      end
      px = bus.x;
      py = bus.y;
      p_adv = bus.coord_vld || (bus.start && !bus.busy);
      p_ok = 1'b1;
    end
  end
  task automatic push_exp(input logic [15:0] sx, sy, sw, sh, input bit mir);
    logic [15:0] xo;
    for (int r = 0; r < int'(sh); r++)
      for (int c = 0; c < int'(sw); c++) begin
        xo = mir ? 16'(int'(sw) - 1 - c) : 16'(c);
        cq.push_back({r == int'(sh) - 1 && c == int'(sw) - 1, 16'(sx + xo), 16'(sy + 16'(r))});
      end
  endtask
  task automatic drive_start(input logic [15:0] sx, sy, sw, sh, input bit mir);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x0 = sx;
    bus.y0 = sy;
    bus.w = sw;
    bus.h = sh;
`ifdef BITMAP_COORD_GEN_MIRROR_EN
    bus.mirror = mir;
`endif
  endtask
  task automatic run_scan(input logic [15:0] sx, sy, sw, sh, input bit mir, tog, spam, exact);
    int d0, s;
    push_exp(sx, sy, sw, sh, mir);
    d0 = done_cnt;
    drive_start(sx, sy, sw, sh, mir);
    s = cyc;
    if (sw == 0 || sh == 0) exp_done = s + 1;
    for (int k = 0; k < 400 && done_cnt == d0; k++) begin
      @(posedge clk);
      #1;
      bus.start = spam && k < 3;
      if (spam) begin
        bus.x0 = 16'd99;
        bus.w = 16'd7;
      end
      bus.ready = !tog || k % 2 == 0;
      if (sw == 0 || sh == 0) chk("empty_busy", bus.busy, 0);
    end
    bus.start = 1'b0;
    bus.ready = 1'b1;
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("coords_left", cq.size(), 0);
    chk("pix_left", pq.size(), 0);
    if (exact) chk("scan_len", last_issue - s, int'(sw) * int'(sh));
  endtask
  initial begin
    int d0;
    bus.start = 1'b0;
    bus.x0 = '0;
    bus.y0 = '0;
    bus.w = '0;
    bus.h = '0;
    bus.ready = 1'b1;
`ifdef BITMAP_COORD_GEN_MIRROR_EN
    bus.mirror = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outs", {bus.x, bus.y, bus.coord_vld, bus.pix_vld, bus.pix_last, bus.busy, bus.done}, 0);
    run_scan(16'd2, 16'd5, 16'd3, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    run_scan(16'd2, 16'd5, 16'd3, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scan(16'd0, 16'd0, 16'd0, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    run_scan(16'hFFFF, 16'd0, 16'd2, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_scan(16'd7, 16'hFFFE, 16'd1, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp(16'd20, 16'd30, 16'd4, 16'd4, 1'b0);
    d0 = done_cnt;
    drive_start(16'd20, 16'd30, 16'd4, 16'd4, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cq.delete();
    pq.delete();
    @(negedge clk);
    chk("midscan_reset_outs", {bus.x, bus.y, bus.coord_vld, bus.pix_vld, bus.pix_last, bus.busy, bus.done}, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("reset_no_done", done_cnt - d0, 0);
    run_scan(16'd20, 16'd30, 16'd4, 16'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    run_scan(16'd10, 16'd0, 16'd3, 16'd1, MIR, 1'b0, 1'b1, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
